// File: rtl/gpio_filt_pkg21.sv
// +--------------------------------------------------------------------+
// | gpio_filt_pkg21 : shared defaults and types for the pin filter     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package gpio_filt_pkg21;

   localparam int NUM_PINS    = 16;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = 8;
   localparam int DIV_W       = 8;

   typedef enum logic {
      MODE_BYPASS   = 1'b0,
      MODE_DEBOUNCE = 1'b1
   } pin_mode_t;

endpackage

`default_nettype wire

// File: rtl/gpio_pin_deb21.sv
// +--------------------------------------------------------------------+
// | gpio_pin_deb21 : one-pin synchroniser, debouncer and change pulse  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module gpio_pin_deb21 #(
   parameter int SYNC_STAGES = gpio_filt_pkg21::SYNC_STAGES,
   parameter int CNT_W       = gpio_filt_pkg21::CNT_W
) (
   input  logic             pclk21,
   input  logic             p_reset21,
   input  logic             i_pin_raw,
   input  logic             i_filt_en,
   input  logic             i_tick,
   input  logic [CNT_W-1:0] i_debounce_len,
   output logic             o_pin_out,
   output logic             o_pin_change
);

   import gpio_filt_pkg21::*;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   out_q, out_d;
   logic                   chg_q, chg_d;
   logic                   w_sync;
   logic [CNT_W:0]         w_cnt_inc;
   pin_mode_t              w_mode;

   assign w_sync    = sync_q[SYNC_STAGES-1];
   assign w_mode    = pin_mode_t'(i_filt_en);
   // One bit wider so the length compare cannot overflow at all-ones.
   assign w_cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_pin_raw};
      out_d  = out_q;
      cnt_d  = cnt_q;
      case (w_mode)
         MODE_BYPASS: begin
            out_d = w_sync;
            cnt_d = '0;
         end
         default: begin
            if (i_tick) begin
               if (w_sync == out_q) begin
                  cnt_d = '0;
               end else if (w_cnt_inc >= {1'b0, i_debounce_len}) begin
                  out_d = w_sync;
                  cnt_d = '0;
               end else begin
                  cnt_d = (&cnt_q) ? cnt_q : w_cnt_inc[CNT_W-1:0];
               end
            end
         end
      endcase
      chg_d = out_d ^ out_q;
   end

   always_ff @(posedge pclk21 or posedge p_reset21) begin
      if (p_reset21) begin
         sync_q <= '0;
         cnt_q  <= '0;
         out_q  <= 1'b0;
         chg_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         chg_q  <= chg_d;
      end
   end

   assign o_pin_out    = out_q;
   assign o_pin_change = chg_q;

endmodule

`default_nettype wire

// File: rtl/gpio_pin_filter21.sv
// +--------------------------------------------------------------------+
// | gpio_pin_filter21 : shared sample prescaler plus per-pin filters   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module gpio_pin_filter21 #(
   parameter int NUM_PINS    = gpio_filt_pkg21::NUM_PINS,
   parameter int SYNC_STAGES = gpio_filt_pkg21::SYNC_STAGES,
   parameter int CNT_W       = gpio_filt_pkg21::CNT_W,
   parameter int DIV_W       = gpio_filt_pkg21::DIV_W
) (
   input  logic                pclk21,
   input  logic                p_reset21,
   input  logic [NUM_PINS-1:0] pin_raw_in21,
   input  logic [NUM_PINS-1:0] filt_en21,
   input  logic [CNT_W-1:0]    debounce_len21,
   input  logic [DIV_W-1:0]    tick_div21,
   output logic [NUM_PINS-1:0] gpio_pin_in21,
   output logic [NUM_PINS-1:0] pin_change21
);

   logic [DIV_W-1:0] div_q, div_d;
   logic             w_tick;

   assign w_tick = (div_q == tick_div21);

   // If tick_div21 drops below the count, the natural overflow wraps it back to 0.
   always_comb begin
      div_d = w_tick ? '0 : div_q + 1'b1;
   end

   always_ff @(posedge pclk21 or posedge p_reset21) begin
      if (p_reset21) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   generate
      for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
         gpio_pin_deb21 #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
         ) u_deb (
            .pclk21         (pclk21),
            .p_reset21      (p_reset21),
            .i_pin_raw      (pin_raw_in21[i]),
            .i_filt_en      (filt_en21[i]),
            .i_tick         (w_tick),
            .i_debounce_len (debounce_len21),
            .o_pin_out      (gpio_pin_in21[i]),
            .o_pin_change   (pin_change21[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire
